// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception/interrupt control stage.
//   - Cause.ExcCode values produced by exc_ctrl
//   - CP0 register numbers that are forwarded from an in-flight mtc0
//   - Status bit positions (IE, EXL, IM field)
//   - MEM-stage exception flag bit positions
//   - FSM state encoding and the EPC helper
package exc_ctrl_pkg;

    // Cause.ExcCode values
    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    // CP0 register addresses
    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    // Status bit indices
    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 8;
    localparam int STATUS_IM_HI = 15;

    // Bit positions inside mem_exc_flags_i
    localparam int FLAG_RI        = 0;
    localparam int FLAG_OV        = 1;
    localparam int FLAG_SYSCALL   = 2;
    localparam int FLAG_BREAK     = 3;
    localparam int FLAG_ADEL_DATA = 4;
    localparam int FLAG_ADES      = 5;
    localparam int FLAG_ERET      = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Restart PC for the faulting instruction: a delay-slot instruction
    // restarts at its branch (32-bit wrap-around is intended).
    function automatic logic [31:0] restart_pc(input logic [31:0] pc, input logic in_ds);
        return in_ds ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// Bundle of every non-clock/reset signal of exc_ctrl.
//   master : pipeline/CP0 side (drives MEM, CP0 and WB views, reads results)
//   slave  : exc_ctrl itself
interface exc_ctrl_if;
    logic [5:0]  int_i;
    logic        mem_valid_i;
    logic [31:0] mem_pc_i;
    logic        mem_in_delay_slot_i;
    logic [6:0]  mem_exc_flags_i;
    logic        mem_adel_fetch_i;
    logic [31:0] mem_badvaddr_i;
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_cause_i;
    logic [31:0] cp0_epc_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_data_i;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        exc_we_o;
    logic [4:0]  exc_code_o;
    logic [31:0] exc_epc_o;
    logic        exc_bd_o;
    logic [31:0] exc_badvaddr_o;
    logic        eret_o;
    logic        stall_req_o;

    modport master (
        output int_i, mem_valid_i, mem_pc_i, mem_in_delay_slot_i, mem_exc_flags_i,
               mem_adel_fetch_i, mem_badvaddr_i, cp0_status_i, cp0_cause_i, cp0_epc_i,
               wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
        input  flush_o, new_pc_o, exc_we_o, exc_code_o, exc_epc_o, exc_bd_o,
               exc_badvaddr_o, eret_o, stall_req_o
    );

    modport slave (
        input  int_i, mem_valid_i, mem_pc_i, mem_in_delay_slot_i, mem_exc_flags_i,
               mem_adel_fetch_i, mem_badvaddr_i, cp0_status_i, cp0_cause_i, cp0_epc_i,
               wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
        output flush_o, new_pc_o, exc_we_o, exc_code_o, exc_epc_o, exc_bd_o,
               exc_badvaddr_o, eret_o, stall_req_o
    );
endinterface

// File: rtl/exc_ctrl_sync2.sv
// Generic two-flop synchronizer, reset to 0.
//   clk, rst : clock and synchronous active-high reset
//   d        : asynchronous input vector
//   q        : synchronized output, two clk cycles behind d
module exc_ctrl_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;
endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt control stage.
// Looks at the MEM-stage instruction and the (WB-forwarded) CP0 state,
// picks the highest-priority exception, interrupt or ERET, and emits a
// registered one-cycle flush with redirect PC and CP0 update fields, then
// holds the front end for DRAIN_CYCLES cycles before accepting new events.
//   clk, rst : clock, synchronous active-high reset
//   bus      : exc_ctrl_if.slave (MEM/CP0/WB inputs, flush/CP0-update outputs)
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int          DRAIN_CYCLES = 3
) (
    input  logic     clk,
    input  logic     rst,
    exc_ctrl_if.slave bus
);
    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

    logic [5:0]  int_sync;
    logic [31:0] status_f;
    logic [31:0] epc_f;
    logic [1:0]  cause_ip_f;
    logic        int_pend;
    logic        take_exc;
    logic        take_eret;
    logic [4:0]  code_next;
    logic [31:0] badvaddr_next;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic        flush_reg;
    logic        exc_we_reg;
    logic        eret_reg;
    logic        stall_reg;
    logic [31:0] new_pc_reg;
    logic [4:0]  code_reg;
    logic [31:0] epc_reg;
    logic        bd_reg;
    logic [31:0] badvaddr_reg;

    exc_ctrl_sync2 #(.WIDTH(6)) u_sync2 (
        .clk (clk),
        .rst (rst),
        .d   (bus.int_i),
        .q   (int_sync)
    );

    // An mtc0 sitting in WB has not reached CP0 yet; use its data instead.
    always_comb begin
        status_f   = bus.cp0_status_i;
        epc_f      = bus.cp0_epc_i;
        cause_ip_f = bus.cp0_cause_i[9:8];
        if (bus.wb_cp0_we_i) begin
            if (bus.wb_cp0_waddr_i == CP0_STATUS) status_f   = bus.wb_cp0_data_i;
            if (bus.wb_cp0_waddr_i == CP0_EPC)    epc_f      = bus.wb_cp0_data_i;
            if (bus.wb_cp0_waddr_i == CP0_CAUSE)  cause_ip_f = bus.wb_cp0_data_i[9:8];
        end
    end

    // IP[7:2] are hardware lines, IP[1:0] the software bits from Cause.
    assign int_pend = status_f[STATUS_IE] & ~status_f[STATUS_EXL] &
                      (|({int_sync, cause_ip_f} & status_f[STATUS_IM_HI:STATUS_IM_LO]));

    // Priority encoder over the MEM-stage events.
    always_comb begin
        take_exc      = 1'b0;
        take_eret     = 1'b0;
        code_next     = EXC_INT;
        badvaddr_next = '0;
        if (bus.mem_valid_i) begin
            if (int_pend) begin
                take_exc = 1'b1;
            end else if (bus.mem_adel_fetch_i) begin
                take_exc      = 1'b1;
                code_next     = EXC_ADEL;
                badvaddr_next = bus.mem_pc_i;
            end else if (bus.mem_exc_flags_i[FLAG_RI]) begin
                take_exc  = 1'b1;
                code_next = EXC_RI;
            end else if (bus.mem_exc_flags_i[FLAG_OV]) begin
                take_exc  = 1'b1;
                code_next = EXC_OV;
            end else if (bus.mem_exc_flags_i[FLAG_SYSCALL]) begin
                take_exc  = 1'b1;
                code_next = EXC_SYS;
            end else if (bus.mem_exc_flags_i[FLAG_BREAK]) begin
                take_exc  = 1'b1;
                code_next = EXC_BP;
            end else if (bus.mem_exc_flags_i[FLAG_ADEL_DATA]) begin
                take_exc      = 1'b1;
                code_next     = EXC_ADEL;
                badvaddr_next = bus.mem_badvaddr_i;
            end else if (bus.mem_exc_flags_i[FLAG_ADES]) begin
                take_exc      = 1'b1;
                code_next     = EXC_ADES;
                badvaddr_next = bus.mem_badvaddr_i;
            end else if (bus.mem_exc_flags_i[FLAG_ERET]) begin
                take_eret = 1'b1;
            end
        end
    end

    // Control FSM; all outputs are registered here. Data outputs keep their
    // last value outside FLUSH; only the strobes return to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            flush_reg    <= 1'b0;
            exc_we_reg   <= 1'b0;
            eret_reg     <= 1'b0;
            stall_reg    <= 1'b0;
            new_pc_reg   <= '0;
            code_reg     <= '0;
            epc_reg      <= '0;
            bd_reg       <= 1'b0;
            badvaddr_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (take_exc) begin
                        state_reg    <= ST_FLUSH;
                        flush_reg    <= 1'b1;
                        exc_we_reg   <= 1'b1;
                        stall_reg    <= 1'b1;
                        new_pc_reg   <= EXC_VECTOR;
                        code_reg     <= code_next;
                        epc_reg      <= restart_pc(bus.mem_pc_i, bus.mem_in_delay_slot_i);
                        bd_reg       <= bus.mem_in_delay_slot_i;
                        badvaddr_reg <= badvaddr_next;
                    end else if (take_eret) begin
                        state_reg  <= ST_FLUSH;
                        flush_reg  <= 1'b1;
                        eret_reg   <= 1'b1;
                        stall_reg  <= 1'b1;
                        new_pc_reg <= epc_f;
                    end
                end
                ST_FLUSH: begin
                    state_reg  <= ST_HOLD;
                    flush_reg  <= 1'b0;
                    exc_we_reg <= 1'b0;
                    eret_reg   <= 1'b0;
                    cnt_reg    <= DRAIN_INIT;
                end
                ST_HOLD: begin
                    // Events seen here are dropped; the refetched instruction
                    // raises them again once we are back in IDLE.
                    if (cnt_reg == 4'd0) begin
                        state_reg <= ST_IDLE;
                        stall_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.flush_o        = flush_reg;
    assign bus.exc_we_o       = exc_we_reg;
    assign bus.eret_o         = eret_reg;
    assign bus.stall_req_o    = stall_reg;
    assign bus.new_pc_o       = new_pc_reg;
    assign bus.exc_code_o     = code_reg;
    assign bus.exc_epc_o      = epc_reg;
    assign bus.exc_bd_o       = bd_reg;
    assign bus.exc_badvaddr_o = badvaddr_reg;

    // Bits of Status/Cause this stage has no use for.
    logic unused_bits;
    assign unused_bits = ^{bus.cp0_cause_i[31:10], bus.cp0_cause_i[7:0],
                           status_f[31:16], status_f[7:2]};
endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;
    localparam int          DRAIN = 3;
    localparam logic [31:0] VEC   = 32'h0000_0020;

    localparam logic [6:0] F_RI = 7'h01, F_OV = 7'h02, F_SYS = 7'h04, F_BRK = 7'h08,
                           F_ADEL = 7'h10, F_ADES = 7'h20, F_ERET = 7'h40;

    typedef struct {
        logic        valid;
        logic [6:0]  flags;
        logic        fetch;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] badv;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic        wb_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        e_flush;
        logic        e_eret;
        logic        e_we;
        logic [4:0]  e_code;
        logic [31:0] e_epc;
        logic        e_bd;
        logic [31:0] e_bad;
        logic [31:0] e_newpc;
    } vec_t;

    typedef struct {
        logic        flush;
        logic        eret;
        logic        we;
        logic [4:0]  code;
        logic [31:0] epc;
        logic        bd;
        logic [31:0] bad;
        logic [31:0] newpc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    vec_t vecs[$];

    exc_ctrl_if bus ();

    exc_ctrl #(.EXC_VECTOR(VEC), .DRAIN_CYCLES(DRAIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(
        input logic v, input logic [6:0] fl, input logic fe, input logic [31:0] pc,
        input logic ds, input logic [31:0] bv, input logic [31:0] st, input logic [31:0] ca,
        input logic [31:0] ep, input logic we, input logic [4:0] wa, input logic [31:0] wd,
        input logic ef, input logic ee, input logic ew, input logic [4:0] ec,
        input logic [31:0] eepc, input logic ebd, input logic [31:0] ebad, input logic [31:0] enp);
        vec_t r;
        r.valid = v;  r.flags = fl;  r.fetch = fe;  r.pc = pc;  r.ds = ds;  r.badv = bv;
        r.status = st; r.cause = ca; r.epc = ep; r.wb_we = we; r.waddr = wa; r.wdata = wd;
        r.e_flush = ef; r.e_eret = ee; r.e_we = ew; r.e_code = ec; r.e_epc = eepc;
        r.e_bd = ebd; r.e_bad = ebad; r.e_newpc = enp;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.int_i = '0;
        bus.mem_valid_i = 1'b0;
        bus.mem_pc_i = '0;
        bus.mem_in_delay_slot_i = 1'b0;
        bus.mem_exc_flags_i = '0;
        bus.mem_adel_fetch_i = 1'b0;
        bus.mem_badvaddr_i = '0;
        bus.cp0_status_i = '0;
        bus.cp0_cause_i = '0;
        bus.cp0_epc_i = '0;
        bus.wb_cp0_we_i = 1'b0;
        bus.wb_cp0_waddr_i = '0;
        bus.wb_cp0_data_i = '0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_flush"}, 32'(bus.flush_o), 0);
        check({tag, "_we"}, 32'(bus.exc_we_o), 0);
        check({tag, "_eret"}, 32'(bus.eret_o), 0);
        check({tag, "_stall"}, 32'(bus.stall_req_o), 0);
        check({tag, "_newpc"}, bus.new_pc_o, 0);
        check({tag, "_code"}, 32'(bus.exc_code_o), 0);
        check({tag, "_epc"}, bus.exc_epc_o, 0);
        check({tag, "_bd"}, 32'(bus.exc_bd_o), 0);
        check({tag, "_bad"}, bus.exc_badvaddr_o, 0);
    endtask

    // Waits out FLUSH+HOLD; the current sample is the FLUSH cycle.
    task automatic drain();
        int n = 1;
        int extra = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (!bus.stall_req_o) break;
            n++;
            if (bus.flush_o || bus.exc_we_o || bus.eret_o) extra++;
        end
        check("stall_len", 32'(n), 32'(1 + DRAIN));
        check("single_flush", 32'(extra), 0);
    endtask

    task automatic apply(input vec_t v, input int idx, input bit do_drain);
        exp_t e;
        exp_t g;
        bus.mem_valid_i = v.valid;
        bus.mem_exc_flags_i = v.flags;
        bus.mem_adel_fetch_i = v.fetch;
        bus.mem_pc_i = v.pc;
        bus.mem_in_delay_slot_i = v.ds;
        bus.mem_badvaddr_i = v.badv;
        bus.cp0_status_i = v.status;
        bus.cp0_cause_i = v.cause;
        bus.cp0_epc_i = v.epc;
        bus.wb_cp0_we_i = v.wb_we;
        bus.wb_cp0_waddr_i = v.waddr;
        bus.wb_cp0_data_i = v.wdata;
        e.flush = v.e_flush; e.eret = v.e_eret; e.we = v.e_we; e.code = v.e_code;
        e.epc = v.e_epc; e.bd = v.e_bd; e.bad = v.e_bad; e.newpc = v.e_newpc;
        sb.push_back(e);
        @(posedge clk); #1;
        $display("txn %0d: pc=%h flags=%b -> flush=%b eret=%b we=%b code=%h epc=%h bd=%b bad=%h npc=%h",
                 idx, v.pc, v.flags, bus.flush_o, bus.eret_o, bus.exc_we_o, bus.exc_code_o,
                 bus.exc_epc_o, bus.exc_bd_o, bus.exc_badvaddr_o, bus.new_pc_o);
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            g = sb.pop_front();
            check($sformatf("v%0d_flush", idx), 32'(bus.flush_o), 32'(g.flush));
            check($sformatf("v%0d_eret", idx), 32'(bus.eret_o), 32'(g.eret));
            check($sformatf("v%0d_we", idx), 32'(bus.exc_we_o), 32'(g.we));
            check($sformatf("v%0d_stall", idx), 32'(bus.stall_req_o), 32'(g.flush));
            if (g.flush) check($sformatf("v%0d_newpc", idx), bus.new_pc_o, g.newpc);
            if (g.we) begin
                check($sformatf("v%0d_code", idx), 32'(bus.exc_code_o), 32'(g.code));
                check($sformatf("v%0d_epc", idx), bus.exc_epc_o, g.epc);
                check($sformatf("v%0d_bd", idx), 32'(bus.exc_bd_o), 32'(g.bd));
                check($sformatf("v%0d_bad", idx), bus.exc_badvaddr_o, g.bad);
            end
        end
        drive_idle();
        if (do_drain && g.flush) drain();
    endtask

    initial begin
        int lat;
        int extra;
        drive_idle();

        //          v  flags          fe pc            ds badv           status        cause         epc          we wa  wdata         flush eret we code   epc            bd bad            newpc
        vecs.push_back(mk(1, F_RI|F_OV,     0, 32'h200,  1, 0,            0,            0,            0,           0, 0,  0,            1, 0, 1, 5'h0a, 32'h1FC,       1, 0,            VEC));
        vecs.push_back(mk(1, F_SYS|F_BRK,   0, 32'h1000, 0, 0,            0,            0,            0,           0, 0,  0,            1, 0, 1, 5'h08, 32'h1000,      0, 0,            VEC));
        vecs.push_back(mk(1, F_BRK,         0, 32'h1004, 0, 0,            0,            0,            0,           0, 0,  0,            1, 0, 1, 5'h09, 32'h1004,      0, 0,            VEC));
        vecs.push_back(mk(1, F_ADEL|F_ADES, 0, 32'h2000, 0, 32'hDEADBEE1, 0,            0,            0,           0, 0,  0,            1, 0, 1, 5'h04, 32'h2000,      0, 32'hDEADBEE1, VEC));
        vecs.push_back(mk(1, F_ADES,        0, 32'h2004, 0, 32'h12345672, 0,            0,            0,           0, 0,  0,            1, 0, 1, 5'h05, 32'h2004,      0, 32'h12345672, VEC));
        vecs.push_back(mk(1, F_RI|F_ERET,   1, 32'h3001, 0, 32'hFFFF0000, 0,            0,            0,           0, 0,  0,            1, 0, 1, 5'h04, 32'h3001,      0, 32'h3001,     VEC));
        vecs.push_back(mk(1, F_OV,          0, 32'h0,    1, 0,            0,            0,            0,           0, 0,  0,            1, 0, 1, 5'h0c, 32'hFFFFFFFC,  1, 0,            VEC));
        vecs.push_back(mk(1, F_ERET,        0, 32'h7000, 0, 0,            0,            0,            32'h300,     1, 14, 32'h400,      1, 1, 0, 5'h00, 0,             0, 0,            32'h400));
        vecs.push_back(mk(1, F_ERET,        0, 32'h7004, 0, 0,            0,            0,            32'h300,     1, 13, 32'h400,      1, 1, 0, 5'h00, 0,             0, 0,            32'h300));
        vecs.push_back(mk(0, F_SYS,         0, 32'h8000, 0, 0,            0,            0,            0,           0, 0,  0,            0, 0, 0, 5'h00, 0,             0, 0,            0));
        vecs.push_back(mk(1, F_ERET,        0, 32'h500,  0, 0,            32'h0101,     32'h0100,     32'h300,     0, 0,  0,            1, 0, 1, 5'h00, 32'h500,       0, 0,            VEC));
        vecs.push_back(mk(1, 7'h00,         0, 32'h600,  0, 0,            32'h0103,     32'h0100,     0,           0, 0,  0,            0, 0, 0, 5'h00, 0,             0, 0,            0));
        vecs.push_back(mk(1, 7'h00,         0, 32'h600,  0, 0,            32'h0103,     32'h0100,     0,           1, 12, 32'h0101,     1, 0, 1, 5'h00, 32'h600,       0, 0,            VEC));
        vecs.push_back(mk(1, 7'h00,         0, 32'h700,  1, 0,            32'h0201,     0,            0,           1, 13, 32'h200,      1, 0, 1, 5'h00, 32'h6FC,       1, 0,            VEC));
        vecs.push_back(mk(1, 7'h00,         0, 32'h800,  0, 0,            32'h0100,     32'h0100,     0,           0, 0,  0,            0, 0, 0, 5'h00, 0,             0, 0,            0));
        vecs.push_back(mk(1, 7'h00,         0, 32'h900,  0, 0,            0,            0,            0,           0, 0,  0,            0, 0, 0, 5'h00, 0,             0, 0,            0));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i, 1'b1);

        // Hardware interrupt through the synchronizer: flush 3 clk after int_i.
        bus.cp0_status_i = 32'h0000_0401;
        bus.mem_valid_i = 1'b1;
        bus.mem_pc_i = 32'h100;
        bus.int_i = 6'b000001;
        lat = 99;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (bus.flush_o) begin
                lat = k;
                break;
            end
        end
        $display("txn int: latency=%0d code=%h epc=%h npc=%h", lat, bus.exc_code_o, bus.exc_epc_o, bus.new_pc_o);
        check("int_latency", 32'(lat), 3);
        check("int_we", 32'(bus.exc_we_o), 1);
        check("int_code", 32'(bus.exc_code_o), 0);
        check("int_epc", bus.exc_epc_o, 32'h100);
        check("int_newpc", bus.new_pc_o, VEC);
        drive_idle();
        drain();

        // Syscall during HOLD is dropped, then accepted when re-presented.
        apply(mk(1, F_RI, 0, 32'hA00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 5'h0a, 32'hA00, 0, 0, VEC), 100, 1'b0);
        bus.mem_valid_i = 1'b1;
        bus.mem_exc_flags_i = F_SYS;
        bus.mem_pc_i = 32'h800;
        @(posedge clk); #1;
        $display("txn hold_sys: flush=%b stall=%b", bus.flush_o, bus.stall_req_o);
        check("hold_drop_flush", 32'(bus.flush_o), 0);
        check("hold_stall", 32'(bus.stall_req_o), 1);
        drive_idle();
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (!bus.stall_req_o) break;
            if (bus.flush_o) extra++;
        end
        check("hold_idle_reached", 32'(bus.stall_req_o), 0);
        check("hold_no_second_flush", 32'(extra), 0);
        apply(mk(1, F_SYS, 0, 32'h800, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 5'h08, 32'h800, 0, 0, VEC), 101, 1'b1);

        // Reset in HOLD: next cycle all zero, then a syscall is accepted.
        apply(mk(1, F_BRK, 0, 32'hB00, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 5'h09, 32'hAFC, 1, 0, VEC), 102, 1'b0);
        @(posedge clk); #1;
        check("pre_rst_stall", 32'(bus.stall_req_o), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        $display("txn rst_hold: flush=%b stall=%b epc=%h", bus.flush_o, bus.stall_req_o, bus.exc_epc_o);
        check_zero("rst_hold");
        rst = 1'b0;
        apply(mk(1, F_SYS, 0, 32'h900, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 5'h08, 32'h900, 0, 0, VEC), 103, 1'b1);

        check("sb_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
Exception/interrupt control stage. It sits directly downstream of the CP0 register block and consumes its status/cause/epc outputs. It also takes the MEM-stage exception flags from the pipeline. It decides whether an exception, interrupt or ERET is taken, then emits a one-cycle pipeline flush, the redirect PC, and the CP0 exception-field update (EPC, Cause.ExcCode/BD, Status.EXL).

Parameters:
EXC_VECTOR, 32'h0000_0020, handler entry PC for every exception and interrupt
DRAIN_CYCLES, 3, cycles spent in HOLD after a flush before new events are accepted (range 1..15)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
int_i  in  6  raw hardware interrupt lines, asynchronous
mem_valid_i  in  1  MEM stage holds a real instruction
mem_pc_i  in  32  PC of the MEM instruction
mem_in_delay_slot_i  in  1  MEM instruction is in a branch delay slot
mem_exc_flags_i  in  7  {eret, ades, adel_data, break, syscall, ov, ri}; bit 0 = ri
mem_adel_fetch_i  in  1  instruction-fetch address error
mem_badvaddr_i  in  32  faulting address for AdEL/AdES
cp0_status_i  in  32  current Status from CP0
cp0_cause_i  in  32  current Cause from CP0
cp0_epc_i  in  32  current EPC from CP0
wb_cp0_we_i  in  1  in-flight mtc0 in WB
wb_cp0_waddr_i  in  5  its destination register
wb_cp0_data_i  in  32  its data
flush_o  out  1  flush all pipeline stages
new_pc_o  out  32  redirect PC, valid while flush_o=1
exc_we_o  out  1  CP0 must capture the exception fields this cycle
exc_code_o  out  5  Cause.ExcCode value
exc_epc_o  out  32  value for EPC
exc_bd_o  out  1  value for Cause.BD
exc_badvaddr_o  out  32  value for BadVAddr
eret_o  out  1  CP0 must clear Status.EXL this cycle
stall_req_o  out  1  high in FLUSH and HOLD; freezes fetch

Behaviour:
- int_i passes through a 2-flop synchronizer; reset value 0. Interrupt latency from int_i to recognition is 2 clk.
- Forwarded views:
  - status_f = wb_data when wb_we and waddr==12, else cp0_status_i.
  - epc_f = wb_data when wb_we and waddr==14, else cp0_epc_i.
  - cause_f[9:8] = wb_data[9:8] when wb_we and waddr==13, else cp0_cause_i[9:8].
- Interrupt pending = status_f[0] (IE) & ~status_f[1] (EXL) & |({int_sync, cause_f[9:8]} & status_f[15:8]).
- Detection runs only in IDLE with mem_valid_i=1. Priority, highest first:
  - Int 0x00
  - AdEL fetch 0x04
  - RI 0x0a
  - Ov 0x0c
  - Syscall 0x08
  - Break 0x09
  - AdEL data 0x04
  - AdES 0x05
  - ERET
- FSM states:
  - IDLE: on detection go to FLUSH (registered, next cycle).
  - FLUSH: exactly one cycle; go to HOLD with counter = DRAIN_CYCLES-1.
  - HOLD: counter decrements each cycle; go to IDLE when it reaches 0. mem_valid_i and all flags are ignored in HOLD.
- FLUSH-cycle outputs for an exception or interrupt:
  - flush_o=1, exc_we_o=1, new_pc_o=EXC_VECTOR.
  - exc_epc_o = mem_pc_i-4 if in delay slot, else mem_pc_i (captured at detection).
  - exc_bd_o = delay-slot flag.
  - exc_badvaddr_o = mem_pc_i for fetch AdEL, mem_badvaddr_i for data AdEL/AdES, else 0.
- FLUSH-cycle outputs for ERET: flush_o=1, eret_o=1, exc_we_o=0, new_pc_o=epc_f captured at detection.
- Outside FLUSH, flush_o, exc_we_o and eret_o are 0. Data outputs hold their last values.
- Reset values: state IDLE, counter 0, all outputs 0.
- Simultaneous events:
  - Several flags in one cycle: highest priority wins; one flush only.
  - Interrupt together with ERET: interrupt wins; EPC = ERET's PC.
  - Event arriving during HOLD: dropped. The flushed instruction is refetched and re-raises it.
- Reset mid-FLUSH/HOLD: next cycle is IDLE with all outputs 0; no partial flush.
- PC arithmetic is 32-bit modulo: 0x0000_0000 in a delay slot gives EPC 0xFFFF_FFFC.

Decomposition:
- Shared defines header:
  - ExcCode constants
  - CP0 register addresses (12/13/14)
  - Status bit indices (IE=0, EXL=1, IM=15:8)
  - FSM state encodings
- One sub-module: sync2, a generic 2-flop synchronizer instantiated with width 6.

Test Plan:
- Status=0x0000_0401 (IE=1, IM2 set), int_i[0] rises, mem_valid=1, pc=0x100 -> flush_o pulses 3 clk after the int_i edge (2 sync flops + registered FLUSH); code 0x00, epc 0x100, new_pc 0x20, stall for 1+DRAIN_CYCLES cycles.
- RI and Ov both set, pc=0x200, delay slot=1 -> code 0x0a, epc 0x1FC, bd=1, single flush.
- ERET with cp0_epc_i=0x300 while WB mtc0 writes EPC=0x400 -> new_pc_o=0x400, eret_o=1, exc_we_o=0.
- Syscall raised in the cycle after FLUSH (HOLD) -> no second flush; it is accepted when re-presented in IDLE.
- EXL=1 with pending interrupt -> no flush; clearing EXL via WB-forwarded status -> interrupt taken the same cycle.
- rst asserted during HOLD -> next cycle all outputs 0; syscall presented in the following cycle is accepted.
